// File: rtl/wb_bram_arb.sv
// wb_bram_arb: two-master Wishbone classic arbiter driving one registered-read block RAM port.
// Locked bursts are honoured; ties are broken against the last master granted.
module wb_bram_arb #(
    parameter int          AW        = 9,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [31:0]   m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [31:0]   m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [1:0]    gnt
);
    typedef enum logic [1:0] {IDLE, ACC, RESP, LOCK} state_t;
    state_t      state;
    logic        cur;
    logic        last_gnt;
    logic        hit_r;
    logic [1:0]  ack_r;
    logic [1:0]  err_r;
    logic        req0;
    logic        req1;
    logic        pick;
    logic        sel_m;
    logic        cyc_g;
    logic        stb_g;
    logic        go_acc;
    logic        hit_s;
    logic        wr_s;
    logic [31:0] adr_s;
    logic [31:0] dat_s;
    logic [3:0]  sel_s;
    logic        unused_adr;
    assign req0  = m0_cyc_i & m0_stb_i;
    assign req1  = m1_cyc_i & m1_stb_i;
    assign pick  = (req0 & req1) ? ~last_gnt : req1;
    // In IDLE the access is loaded for the master being granted this edge.
    assign sel_m = (state == IDLE) ? pick : cur;
    assign adr_s = sel_m ? m1_adr_i : m0_adr_i;
    assign dat_s = sel_m ? m1_dat_i : m0_dat_i;
    assign sel_s = sel_m ? m1_sel_i : m0_sel_i;
    assign wr_s  = sel_m ? m1_we_i : m0_we_i;
    assign cyc_g = cur ? m1_cyc_i : m0_cyc_i;
    assign stb_g = cur ? m1_stb_i : m0_stb_i;
    assign hit_s = adr_s[31:AW+2] == BASE_ADDR[31:AW+2];
    assign go_acc = (state == IDLE) ? (req0 | req1)
                  : (state == RESP || state == LOCK) && cyc_g && stb_g;
    assign unused_adr = ^adr_s[1:0];
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            cur       <= 1'b0;
            last_gnt  <= 1'b1;
            gnt       <= 2'b00;
            hit_r     <= 1'b0;
            ack_r     <= 2'b00;
            err_r     <= 2'b00;
            mem_en    <= 1'b0;
            mem_we    <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            mem_en    <= go_acc & hit_s;
            mem_we    <= (go_acc & hit_s) ? (sel_s & {4{wr_s}}) : 4'h0;
            mem_addr  <= (go_acc & hit_s) ? adr_s[AW+1:2] : '0;
            mem_wdata <= (go_acc & hit_s) ? dat_s : 32'h0;
            hit_r     <= hit_s;
            ack_r     <= 2'b00;
            err_r     <= 2'b00;
            case (state)
                IDLE: begin
                    if (go_acc) begin
                        cur   <= pick;
                        gnt   <= pick ? 2'b10 : 2'b01;
                        state <= ACC;
                    end
                end
                ACC: begin
                    // An aborted cycle still lets the BRAM access finish but gets no termination.
                    if (cyc_g) begin
                        ack_r[cur] <= hit_r;
                        err_r[cur] <= ~hit_r;
                    end
                    state <= RESP;
                end
                default: begin
                    state <= go_acc ? ACC : cyc_g ? LOCK : IDLE;
                    if (!cyc_g) begin
                        gnt      <= 2'b00;
                        last_gnt <= cur;
                    end
                end
            endcase
        end
    end
    assign m0_ack_o = ack_r[0] & m0_cyc_i;
    assign m0_err_o = err_r[0] & m0_cyc_i;
    assign m1_ack_o = ack_r[1] & m1_cyc_i;
    assign m1_err_o = err_r[1] & m1_cyc_i;
    assign m0_dat_o = m0_ack_o ? mem_rdata : 32'h0;
    assign m1_dat_o = m1_ack_o ? mem_rdata : 32'h0;
endmodule

// File: tb/tb_wb_bram_arb.sv
// tb_wb_bram_arb: scoreboard bench for wb_bram_arb with a behavioural registered-read BRAM.
module tb_wb_bram_arb;
    logic        sys_clk;
    logic        sys_rst = 1'b1;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [31:0] m0_adr = 0, m0_dat = 0;
    logic [3:0]  m0_sel = 0;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m1_adr = 0, m1_dat = 0;
    logic [3:0]  m1_sel = 0;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic [1:0]  gnt;

    wb_bram_arb dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .gnt(gnt)
    );

    typedef struct packed { logic err; logic chk; logic [31:0] data; } exp_t;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] bram    [512];
    logic [31:0] ref_mem [512];
    logic        h_en   [64];
    logic [3:0]  h_we   [64];
    logic [8:0]  h_addr [64];
    logic [31:0] h_wd   [64];
    logic [1:0]  h_gnt  [64];
    int          cyc_n = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic        mon_a, mon_e, mon_empty;
    logic [31:0] mon_d;
    exp_t        mon_x;

    initial begin
        sys_clk = 0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sl);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sl[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) begin
            bram[i]    = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        bram[7]    = 32'h0000_0013;
        ref_mem[7] = 32'h0000_0013;
    end

    always @(posedge sys_clk) begin
        if (mem_en) begin
            bram[mem_addr] <= merge(bram[mem_addr], mem_wdata, mem_we);
            mem_rdata      <= bram[mem_addr];
        end
    end

    // Monitor: history of BRAM pins per cycle plus scoreboard pops on every termination.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            h_en[6'(cyc_n)]   = mem_en;
            h_we[6'(cyc_n)]   = mem_we;
            h_addr[6'(cyc_n)] = mem_addr;
            h_wd[6'(cyc_n)]   = mem_wdata;
            h_gnt[6'(cyc_n)]  = gnt;
            if (!mem_en) begin
                compared++;
                if (mem_we !== 4'h0 || mem_addr !== 9'h0 || mem_wdata !== 32'h0) begin
                    mismatched++;
                    $display("FAIL mem_idle we=%h addr=%h wdata=%h required all zero", mem_we, mem_addr, mem_wdata);
                end
            end
            compared++;
            if (((m0_ack_o | m0_err_o) & (m1_ack_o | m1_err_o)) | (m0_ack_o & m0_err_o) | (m1_ack_o & m1_err_o)) begin
                mismatched++;
                $display("FAIL term_excl ack0=%b err0=%b ack1=%b err1=%b required at most one", m0_ack_o, m0_err_o, m1_ack_o, m1_err_o);
            end
            for (int m = 0; m < 2; m++) begin
                mon_a = (m == 1) ? m1_ack_o : m0_ack_o;
                mon_e = (m == 1) ? m1_err_o : m0_err_o;
                mon_d = (m == 1) ? m1_dat_o : m0_dat_o;
                compared++;
                if (mon_a | mon_e) begin
                    mon_empty = 1'b0;
                    if (m == 0) begin
                        if (q0.size() == 0) mon_empty = 1'b1; else mon_x = q0.pop_front();
                    end else begin
                        if (q1.size() == 0) mon_empty = 1'b1; else mon_x = q1.pop_front();
                    end
                    if (mon_empty) begin
                        mismatched++;
                        $display("FAIL sb_unexpected m%0d ack=%b err=%b with no access outstanding", m, mon_a, mon_e);
                    end else if (mon_e !== mon_x.err || (mon_x.chk && mon_d !== mon_x.data)) begin
                        mismatched++;
                        $display("FAIL sb_m%0d got err=%b dat=%h expected err=%b dat=%h", m, mon_e, mon_d, mon_x.err, mon_x.data);
                    end
                end else if (mon_d !== 32'h0) begin
                    mismatched++;
                    $display("FAIL dat_idle_m%0d got %h expected 0", m, mon_d);
                end
            end
        end
    end

    task automatic drive(input int m, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        if (m == 0) begin
            m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_dat = d; m0_sel = sl;
        end else begin
            m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_dat = d; m1_sel = sl;
        end
    endtask

    task automatic release_m(input int m);
        drive(m, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    // Issues one access, queues its expected termination, returns cycles until ack/err; cyc stays high.
    task automatic xfer(input int m, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] sl, output int lat);
        int   t0;
        exp_t e;
        t0     = cyc_n;
        e.err  = a[31:11] != 21'h0;
        e.chk  = !w || e.err;
        e.data = e.err ? 32'h0 : ref_mem[a[10:2]];
        if (w && !e.err) ref_mem[a[10:2]] = merge(ref_mem[a[10:2]], d, sl);
        if (m == 0) q0.push_back(e); else q1.push_back(e);
        drive(m, 1, 1, w, a, d, sl);
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge sys_clk);
            if (m == 0 ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o)) lat = cyc_n - t0;
        end
        #1;
        drive(m, 1, 0, w, a, d, sl);
        if (lat < 0) begin
            compared++;
            mismatched++;
            $display("FAIL timeout_m%0d no ack/err within 40 cycles, required one", m);
        end
    endtask

    task automatic test_reset();
        drive(0, 1, 1, 0, 32'h1C, 32'h0, 4'hF);
        repeat (2) @(negedge sys_clk);
        compared++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'h0) begin
            mismatched++;
            $display("FAIL rst_term got %b expected 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        compared++;
        if (gnt !== 2'b00 || mem_en !== 1'b0 || mem_we !== 4'h0 || mem_addr !== 9'h0 || mem_wdata !== 32'h0) begin
            mismatched++;
            $display("FAIL rst_mem gnt=%b en=%b we=%h addr=%h wd=%h expected all zero", gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        compared++;
        if (m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0) begin
            mismatched++;
            $display("FAIL rst_dat got %h/%h expected 0", m0_dat_o, m1_dat_o);
        end
        #1;
        release_m(0);
        sys_rst = 1'b0;
    endtask

    task automatic tie(input logic [31:0] a0, input logic [31:0] a1, input string tag);
        int la, lb;
        fork
            begin xfer(0, 0, a0, 32'h0, 4'hF, la); release_m(0); end
            begin xfer(1, 0, a1, 32'h0, 4'hF, lb); release_m(1); end
        join
        compared++;
        if (la !== 2) begin mismatched++; $display("FAIL %s_m0_lat got %0d expected 2", tag, la); end
        compared++;
        if (lb !== 5) begin mismatched++; $display("FAIL %s_m1_lat got %0d expected 5", tag, lb); end
    endtask

    task automatic test_tie();
        idle(1);
        tie(32'h0C, 32'h14, "tie1");
        idle(2);
        tie(32'h08, 32'h04, "tie2");
    endtask

    task automatic test_single_read();
        int l, t0;
        idle(2);
        t0 = cyc_n;
        xfer(0, 0, 32'h1C, 32'h0, 4'hF, l);
        release_m(0);
        compared++;
        if (l !== 2) begin mismatched++; $display("FAIL rd_lat got %0d expected 2", l); end
        compared++;
        if (h_en[6'(t0 + 1)] !== 1'b1 || h_addr[6'(t0 + 1)] !== 9'd7 || h_we[6'(t0 + 1)] !== 4'h0) begin
            mismatched++;
            $display("FAIL rd_mem en=%b addr=%0d we=%h expected 1/7/0", h_en[6'(t0 + 1)], h_addr[6'(t0 + 1)], h_we[6'(t0 + 1)]);
        end
        compared++;
        if (h_gnt[6'(t0 + 1)] !== 2'b01) begin mismatched++; $display("FAIL rd_gnt got %b expected 01", h_gnt[6'(t0 + 1)]); end
        idle(1);
        compared++;
        if (h_gnt[6'(t0 + 3)] !== 2'b00) begin mismatched++; $display("FAIL rd_gnt_idle got %b expected 00", h_gnt[6'(t0 + 3)]); end
    endtask

    task automatic test_byte_write();
        int l, t0;
        idle(2);
        t0 = cyc_n;
        xfer(1, 1, 32'h40, 32'hA5A5_A5A5, 4'b0010, l);
        release_m(1);
        compared++;
        if (l !== 2) begin mismatched++; $display("FAIL wr_lat got %0d expected 2", l); end
        compared++;
        if (h_en[6'(t0 + 1)] !== 1'b1 || h_we[6'(t0 + 1)] !== 4'b0010 || h_addr[6'(t0 + 1)] !== 9'd16 || h_wd[6'(t0 + 1)] !== 32'hA5A5_A5A5) begin
            mismatched++;
            $display("FAIL wr_mem en=%b we=%b addr=%0d wd=%h expected 1/0010/16/a5a5a5a5",
                     h_en[6'(t0 + 1)], h_we[6'(t0 + 1)], h_addr[6'(t0 + 1)], h_wd[6'(t0 + 1)]);
        end
        compared++;
        if (h_gnt[6'(t0 + 1)] !== 2'b10) begin mismatched++; $display("FAIL wr_gnt got %b expected 10", h_gnt[6'(t0 + 1)]); end
        idle(2);
        xfer(1, 0, 32'h40, 32'h0, 4'hF, l);
        release_m(1);
        compared++;
        if (l !== 2) begin mismatched++; $display("FAIL wr_rd_lat got %0d expected 2", l); end
        compared++;
        if (bram[16] !== 32'hC0DE_A510) begin mismatched++; $display("FAIL wr_word got %h expected c0dea510", bram[16]); end
    endtask

    task automatic test_burst();
        int la, lb, lc, lm;
        idle(2);
        fork
            begin
                xfer(0, 0, 32'h10, 32'h0, 4'hF, la);
                xfer(0, 0, 32'h14, 32'h0, 4'hF, lb);
                xfer(0, 0, 32'h18, 32'h0, 4'hF, lc);
                release_m(0);
            end
            begin
                idle(1);
                xfer(1, 0, 32'h1C, 32'h0, 4'hF, lm);
                release_m(1);
            end
        join
        compared++;
        if (la !== 2 || lb !== 2 || lc !== 2) begin
            mismatched++;
            $display("FAIL burst_m0_lat got %0d/%0d/%0d expected 2/2/2", la, lb, lc);
        end
        compared++;
        if (lm !== 8) begin mismatched++; $display("FAIL burst_m1_lat got %0d expected 8", lm); end
    endtask

    task automatic test_out_of_window();
        int l, t0, diffs;
        idle(2);
        t0 = cyc_n;
        xfer(0, 1, 32'h0000_0800, 32'hDEAD_BEEF, 4'hF, l);
        release_m(0);
        compared++;
        if (l !== 2) begin mismatched++; $display("FAIL oow_lat got %0d expected 2", l); end
        compared++;
        if (h_en[6'(t0 + 1)] !== 1'b0 || h_we[6'(t0 + 1)] !== 4'h0) begin
            mismatched++;
            $display("FAIL oow_mem en=%b we=%h expected 0/0", h_en[6'(t0 + 1)], h_we[6'(t0 + 1)]);
        end
        idle(2);
        xfer(0, 0, 32'h0000_0804, 32'h0, 4'hF, l);
        release_m(0);
        compared++;
        if (l !== 2) begin mismatched++; $display("FAIL oow_rd_lat got %0d expected 2", l); end
        idle(1);
        diffs = 0;
        for (int i = 0; i < 512; i++) if (bram[i] !== ref_mem[i]) diffs++;
        compared++;
        if (diffs != 0 || bram[0] !== 32'hC0DE_0000) begin
            mismatched++;
            $display("FAIL oow_bram got %0d differing words, word0=%h expected 0 and c0de0000", diffs, bram[0]);
        end
    endtask

    task automatic test_abort();
        int l;
        idle(2);
        drive(1, 1, 1, 0, 32'h30, 32'h0, 4'hF);
        @(negedge sys_clk);
        compared++;
        if (mem_en !== 1'b1 || mem_addr !== 9'd12 || gnt !== 2'b10) begin
            mismatched++;
            $display("FAIL abort_acc en=%b addr=%0d gnt=%b expected 1/12/10", mem_en, mem_addr, gnt);
        end
        #1;
        release_m(1);
        @(negedge sys_clk);
        compared++;
        if (m1_ack_o !== 1'b0 || m1_err_o !== 1'b0 || gnt !== 2'b10) begin
            mismatched++;
            $display("FAIL abort_resp ack=%b err=%b gnt=%b expected 0/0/10", m1_ack_o, m1_err_o, gnt);
        end
        @(negedge sys_clk);
        compared++;
        if (gnt !== 2'b00) begin mismatched++; $display("FAIL abort_idle gnt got %b expected 00", gnt); end
        #1;
        xfer(0, 0, 32'h30, 32'h0, 4'hF, l);
        release_m(0);
        compared++;
        if (l !== 2) begin mismatched++; $display("FAIL abort_next_lat got %0d expected 2", l); end
    endtask

    task automatic test_reset_mid();
        int l;
        idle(2);
        xfer(0, 0, 32'h20, 32'h0, 4'hF, l);
        release_m(0);
        idle(2);
        xfer(1, 0, 32'h24, 32'h0, 4'hF, l);
        compared++;
        if (l !== 2) begin mismatched++; $display("FAIL rstmid_lat got %0d expected 2", l); end
        sys_rst = 1'b1;
        #1;
        compared++;
        if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0 || gnt !== 2'b00 || mem_en !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_clear ack=%b dat=%h gnt=%b en=%b expected 0/0/00/0", m1_ack_o, m1_dat_o, gnt, mem_en);
        end
        release_m(1);
        @(negedge sys_clk);
        #1;
        sys_rst = 1'b0;
        q0.delete();
        q1.delete();
        idle(1);
        tie(32'h28, 32'h2C, "rst_tie");
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_read();
        test_byte_write();
        test_burst();
        test_out_of_window();
        test_abort();
        test_reset_mid();
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within 200000 time units");
        $fatal(1);
    end
endmodule
